// File: rtl/drum_voice_mixer.sv
// Four decaying square-wave drum voices mixed into a saturated stereo sample stream.
// Build option DRUM_STEREO_PAN_EN pans voices 0,2 left and 1,3 right.
//
// voice state | meaning
// V_IDLE      | silent, contributes 0 to the mix
// V_PLAY      | square tone running, amplitude decays on every sample tick
//
// output state | meaning
// WAIT_TICK    | nothing held for the audio FIFO
// PENDING      | a mixed pair is held, waiting for audio_out_allowed
module drum_voice_mixer #(
  parameter int SAMPLE_DIV       = 1042,
  parameter int BASE_HALF_PERIOD = 3000,
  parameter int AMP_INIT         = 10000000,
  parameter int DECAY_SHIFT      = 10
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [3:0]  trig,
  input  logic [3:0]  pitch_sel,
  input  logic        audio_out_allowed,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        write_audio_out,
  output logic [3:0]  busy,
  output logic        overrun
);

  typedef enum logic {V_IDLE, V_PLAY} voice_state_e;
  typedef enum logic {WAIT_TICK, PENDING} out_state_e;

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [30:0] AMP0 = 31'(AMP_INIT);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick;
  voice_state_e       vst_q [4];
  voice_state_e       vst_d [4];
  logic [30:0]        amp_q [4];
  logic [30:0]        amp_d [4];
  logic [30:0]        dec   [4];
  logic               sq_q  [4];
  logic               sq_d  [4];
  logic [19:0]        ph_q  [4];
  logic [19:0]        ph_d  [4];
  logic [19:0]        hp_q  [4];
  logic [19:0]        hp_d  [4];
  logic signed [31:0] vval  [4];
  logic signed [33:0] sum_l;
  logic signed [31:0] mix_l, mix_r;
`ifdef DRUM_STEREO_PAN_EN
  logic signed [33:0] sum_r;
`endif
  out_state_e         ost_q, ost_d;
  logic [31:0]        hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [31:0]        left_q, left_d, right_q, right_d;
  logic               write_q, write_d, overrun_q, overrun_d;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] s);
    if (s > 34'sd2147483647)
      return 32'sh7fffffff;
    else if (s < -34'sd2147483648)
      return 32'sh80000000;
    else
      return s[31:0];
  endfunction

  always_comb begin
    tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // The sample latched on a tick is built from the post-update voice state,
  // so a fresh trigger or this tick's decay is already audible in it.
  always_comb begin
    for (int v = 0; v < 4; v++) begin
      vst_d[v] = vst_q[v];
      amp_d[v] = amp_q[v];
      sq_d[v]  = sq_q[v];
      ph_d[v]  = ph_q[v];
      hp_d[v]  = hp_q[v];
      dec[v]   = amp_q[v] >> DECAY_SHIFT;
      if (dec[v] == '0)
        dec[v] = 31'd1;
      if (trig[v]) begin
        vst_d[v] = V_PLAY;
        amp_d[v] = AMP0;
        sq_d[v]  = 1'b1;
        ph_d[v]  = '0;
        hp_d[v]  = (20'(BASE_HALF_PERIOD) + 20'({pitch_sel, 12'h000})) << v;
      end else if (vst_q[v] == V_PLAY) begin
        if (ph_q[v] == hp_q[v] - 20'd1) begin
          ph_d[v] = '0;
          sq_d[v] = ~sq_q[v];
        end else begin
          ph_d[v] = ph_q[v] + 20'd1;
        end
        if (tick) begin
          if (amp_q[v] <= dec[v]) begin
            amp_d[v] = '0;
            vst_d[v] = V_IDLE;
          end else begin
            amp_d[v] = amp_q[v] - dec[v];
          end
        end
      end
      if (vst_d[v] == V_IDLE)
        vval[v] = '0;
      else if (sq_d[v])
        vval[v] = $signed({1'b0, amp_d[v]});
      else
        vval[v] = -$signed({1'b0, amp_d[v]});
    end
  end

  always_comb begin
`ifdef DRUM_STEREO_PAN_EN
    sum_l = 34'(vval[0]) + 34'(vval[2]) + 34'(vval[1] >>> 1) + 34'(vval[3] >>> 1);
    sum_r = 34'(vval[1]) + 34'(vval[3]) + 34'(vval[0] >>> 1) + 34'(vval[2] >>> 1);
    mix_l = sat32(sum_l);
    mix_r = sat32(sum_r);
`else
    sum_l = 34'(vval[0]) + 34'(vval[1]) + 34'(vval[2]) + 34'(vval[3]);
    mix_l = sat32(sum_l);
    mix_r = mix_l;
`endif
  end

  // A write and a tick in the same cycle: the old pair goes out, the new one is held.
  always_comb begin
    ost_d     = ost_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    left_d    = left_q;
    right_d   = right_q;
    write_d   = 1'b0;
    overrun_d = overrun_q;
    if (ost_q == PENDING && audio_out_allowed) begin
      write_d = 1'b1;
      left_d  = hold_l_q;
      right_d = hold_r_q;
      ost_d   = WAIT_TICK;
    end
    if (tick) begin
      hold_l_d = mix_l;
      hold_r_d = mix_r;
      ost_d    = PENDING;
      if (ost_q == PENDING && !audio_out_allowed)
        overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      ost_q     <= WAIT_TICK;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      write_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int v = 0; v < 4; v++) begin
        vst_q[v] <= V_IDLE;
        amp_q[v] <= '0;
        sq_q[v]  <= 1'b0;
        ph_q[v]  <= '0;
        hp_q[v]  <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      ost_q     <= ost_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      write_q   <= write_d;
      overrun_q <= overrun_d;
      for (int v = 0; v < 4; v++) begin
        vst_q[v] <= vst_d[v];
        amp_q[v] <= amp_d[v];
        sq_q[v]  <= sq_d[v];
        ph_q[v]  <= ph_d[v];
        hp_q[v]  <= hp_d[v];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < 4; v++)
      busy[v] = (vst_q[v] == V_PLAY);
  end

  assign left_channel_audio_out  = left_q;
  assign right_channel_audio_out = right_q;
  assign write_audio_out         = write_q;
  assign overrun                 = overrun_q;

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Bench for drum_voice_mixer: directed steps plus random triggers, checked against
// an arithmetic model of voices, sample ticks and the FIFO hand-off.
module tb_drum_voice_mixer;
  localparam int     SD  = 1042;
  localparam int     BHP = 3000;
  localparam longint AI  = 10000000;
  localparam int     DS  = 10;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic        reset_n = 1'b0;
  logic        allowed = 1'b1;
  logic [3:0]  trig = '0, trig_d = '0, pitch_sel = '0;
  logic [31:0] left, right, s_left, s_right, d_left, d_right;
  logic        wr, s_wr, d_wr, ovr, s_ovr, d_ovr;
  logic [3:0]  busy, s_busy, d_busy;

  drum_voice_mixer dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .trig(trig), .pitch_sel(pitch_sel),
    .audio_out_allowed(allowed), .left_channel_audio_out(left),
    .right_channel_audio_out(right), .write_audio_out(wr), .busy(busy), .overrun(ovr));

  drum_voice_mixer #(.AMP_INIT(1 << 30)) dut_s (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .trig(trig), .pitch_sel(pitch_sel),
    .audio_out_allowed(allowed), .left_channel_audio_out(s_left),
    .right_channel_audio_out(s_right), .write_audio_out(s_wr), .busy(s_busy), .overrun(s_ovr));

  drum_voice_mixer #(.SAMPLE_DIV(16), .BASE_HALF_PERIOD(5), .AMP_INIT(40), .DECAY_SHIFT(2)) dut_d (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .trig(trig_d), .pitch_sel(pitch_sel),
    .audio_out_allowed(allowed), .left_channel_audio_out(d_left),
    .right_channel_audio_out(d_right), .write_audio_out(d_wr), .busy(d_busy), .overrun(d_ovr));

  int errors = 0;
  int checks = 0;

  // model state: edge_n is the index of the next rising edge since reset release
  longint edge_n = 0;
  int     m_cnt = 0;
  bit     m_play [4];
  longint m_amp [4];
  longint m_t0 [4];
  longint m_hp [4];
  bit     m_pend = 0, m_over = 0, x_write = 0;
  longint m_hl = 0, m_hr = 0, x_l = 0, x_r = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint s);
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  function automatic int decay_ticks(input longint a0, input int sh);
    longint a, d;
    int n;
    a = a0;
    n = 0;
    while (a > 0) begin
      d = a >> sh;
      if (d < 1) d = 1;
      a = a - d;
      n++;
    end
    return n;
  endfunction

  task automatic model_edge();
    bit tk;
    longint d;
    longint vv [4];
    if (!reset_n) begin
      for (int v = 0; v < 4; v++) begin
        m_play[v] = 0; m_amp[v] = 0; m_t0[v] = 0; m_hp[v] = 1;
      end
      m_cnt = 0; m_pend = 0; m_over = 0; x_write = 0;
      m_hl = 0; m_hr = 0; x_l = 0; x_r = 0; edge_n = 0;
      return;
    end
    tk = (m_cnt == SD - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    x_write = m_pend && allowed;
    if (x_write) begin
      x_l = m_hl;
      x_r = m_hr;
    end
    if (tk && m_pend && !allowed) m_over = 1;
    if (x_write) m_pend = 0;
    for (int v = 0; v < 4; v++) begin
      if (trig[v]) begin
        m_play[v] = 1;
        m_amp[v]  = AI;
        m_t0[v]   = edge_n;
        m_hp[v]   = (longint'(BHP) + longint'(pitch_sel) * 4096) << v;
      end else if (m_play[v] && tk) begin
        d = m_amp[v] >> DS;
        if (d < 1) d = 1;
        m_amp[v] = m_amp[v] - d;
        if (m_amp[v] == 0) m_play[v] = 0;
      end
    end
    if (tk) begin
      for (int v = 0; v < 4; v++) begin
        if (!m_play[v]) vv[v] = 0;
        else if (((edge_n - m_t0[v]) / m_hp[v]) % 2 == 0) vv[v] = m_amp[v];
        else vv[v] = -m_amp[v];
      end
`ifdef DRUM_STEREO_PAN_EN
      m_hl = sat(vv[0] + vv[2] + (vv[1] >>> 1) + (vv[3] >>> 1));
      m_hr = sat(vv[1] + vv[3] + (vv[0] >>> 1) + (vv[2] >>> 1));
`else
      m_hl = sat(vv[0] + vv[1] + vv[2] + vv[3]);
      m_hr = m_hl;
`endif
      m_pend = 1;
    end
    edge_n++;
  endtask

  task automatic check_cycle();
    chk("write", longint'(wr), longint'(x_write));
    chk("left", longint'($signed(left)), x_l);
    chk("right", longint'($signed(right)), x_r);
    chk("busy", longint'(busy), longint'({m_play[3], m_play[2], m_play[1], m_play[0]}));
    chk("overrun", longint'(ovr), longint'(m_over));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      check_cycle();
      trig   = '0;
      trig_d = '0;
    end
  endtask

  task automatic run_until_write(input int limit, output longint e);
    bit got;
    got = 0;
    e = -1;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (wr) begin
        got = 1;
        e = edge_n - 1;
        break;
      end
    end
    chk("write_timeout", longint'(got), 1);
  endtask

  task automatic align16();
    for (int i = 0; i < 32; i++) begin
      if (edge_n % 16 == 0) break;
      step(1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e1, e2;
    int nwr, nd, k;

    step(3);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_left", longint'($signed(left)), 0);
    chk("reset_write", longint'(wr), 0);
    chk("reset_overrun", longint'(ovr), 0);

    reset_n = 1'b1;
    run_until_write(SD + 10, e1);
    chk("first_write_edge", e1, SD);
    run_until_write(SD + 10, e2);
    chk("write_period", e2 - e1, SD);
    chk("idle_sample", longint'($signed(left)), 0);

    trig = 4'b0001;
    pitch_sel = 4'd0;
    step(1);
    chk("busy0_on_trig", longint'(busy[0]), 1);
    run_until_write(SD + 10, e1);
    chk("voice0_first_sample", longint'($signed(left)), 9990235);
    for (int i = 0; i < 3; i++) run_until_write(SD + 10, e1);

    trig = 4'b0010;
    pitch_sel = 4'd3;
    step(1);
    run_until_write(SD + 10, e1);
    run_until_write(SD + 10, e1);
    trig = 4'b0010;
    pitch_sel = 4'($urandom);
    step(1);
    chk("busy1_retrig", longint'(busy[1]), 1);
    run_until_write(SD + 10, e1);
    chk("busy1_after_tick", longint'(busy[1]), 1);

    trig = 4'b1111;
    pitch_sel = 4'd0;
    step(1);
    run_until_write(SD + 10, e1);
`ifdef DRUM_STEREO_PAN_EN
    chk("all4_sample", longint'($signed(left)), 29970704);
`else
    chk("all4_sample", longint'($signed(left)), 39960940);
`endif
    chk("all4_saturate_l", longint'($signed(s_left)), 2147483647);
    chk("all4_saturate_r", longint'($signed(s_right)), 2147483647);

    allowed = 1'b0;
    step(3000);
    chk("overrun_set", longint'(ovr), 1);
    allowed = 1'b1;
    nwr = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (wr) nwr++;
    end
    chk("single_write_after_stall", nwr, 1);

    for (int i = 0; i < 12000; i++) begin
      allowed = ($urandom_range(0, 3) != 0);
      for (int v = 0; v < 4; v++) trig[v] = ($urandom_range(0, 799) == 0);
      pitch_sel = 4'($urandom);
      step(1);
    end

    allowed = 1'b0;
    trig = 4'b0101;
    step(1);
    for (int i = 0; i < SD + 5; i++) begin
      if (m_pend) break;
      step(1);
    end
    chk("pending_before_reset", longint'(m_pend), 1);
    reset_n = 1'b0;
    step(1);
    chk("reset_mid_busy", longint'(busy), 0);
    chk("reset_mid_left", longint'($signed(left)), 0);
    chk("reset_mid_overrun", longint'(ovr), 0);
    reset_n = 1'b1;
    allowed = 1'b1;
    run_until_write(SD + 10, e1);
    chk("post_reset_write_edge", e1, SD);

    nd = decay_ticks(40, 2);
    k = 15 + 16 * (nd - 1) - 1;
    align16();
    trig_d = 4'b0001;
    step(1);
    chk("small_busy_start", longint'(d_busy[0]), 1);
    step(k);
    chk("small_busy_before_zero", longint'(d_busy[0]), 1);
    step(1);
    chk("small_idle_at_zero", longint'(d_busy[0]), 0);

    align16();
    trig_d = 4'b0001;
    step(1);
    step(k);
    trig_d = 4'b0001;
    step(1);
    chk("small_retrig_wins", longint'(d_busy[0]), 1);
    step(48);
    chk("small_retrig_playing", longint'(d_busy[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/drum_voice_mixer.md
DRUM_VOICE_MIXER -- requirements
Module: drum_voice_mixer

Interface
REQ-001 Parameter SAMPLE_DIV, 1042, CLOCK_50 cycles per output sample tick (about 48 kHz).
REQ-002 Parameter BASE_HALF_PERIOD, 3000, base tone half-period in clocks.
REQ-003 Parameter AMP_INIT, 10000000, envelope start amplitude, unsigned 31-bit.
REQ-004 Parameter DECAY_SHIFT, 10, envelope decay shift per sample tick.
REQ-005 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 trig  in  4  one-cycle start pulse per voice; bit v drives voice v.
REQ-008 pitch_sel  in  4  pitch select; sampled per voice on its trigger.
REQ-009 audio_out_allowed  in  1  downstream audio FIFO can accept one sample pair.
REQ-010 left_channel_audio_out  out  32  signed left sample; valid while write_audio_out=1.
REQ-011 right_channel_audio_out  out  32  signed right sample; valid while write_audio_out=1.
REQ-012 write_audio_out  out  1  one-cycle write strobe to the audio FIFO.
REQ-013 busy  out  4  bit v high while voice v is in PLAY.
REQ-014 overrun  out  1  sticky; a pending sample was overwritten before it was written.

Function
REQ-015 Tick counter runs 0..SAMPLE_DIV-1, then wraps; a tick is one cycle at the wrap.
REQ-016 Each voice has FSM IDLE/PLAY; trig[v] in any state -> PLAY, amp=AMP_INIT, square=1, phase counter=0, half-period latched.
REQ-017 Latched half-period HP_v = (BASE_HALF_PERIOD + pitch_sel*4096) << v, held in a 20-bit register.
REQ-018 In PLAY, phase counter counts every clock; at HP_v-1 it wraps to 0 and square toggles.
REQ-019 On each tick in PLAY, amp <= amp - max(amp>>DECAY_SHIFT, 1); amp reaching 0 -> IDLE, busy[v]=0.
REQ-020 A trig coinciding with the decay-to-0 tick wins: the voice restarts in PLAY.
REQ-021 Voice value = +amp if square=1, -amp if square=0; 0 in IDLE; signed 32-bit.
REQ-022 Mix = signed sum of the voice values in at least 34 bits, saturated to [-2^31, 2^31-1].
REQ-023 Output FSM states: WAIT_TICK, PENDING.
REQ-024 On a tick, the mix is latched into the holding registers and the FSM enters PENDING.
REQ-025 In PENDING with audio_out_allowed=1: write_audio_out=1 for exactly 1 cycle, outputs show the held pair, then WAIT_TICK.
REQ-026 Tick while in PENDING, no write that cycle: holding registers are overwritten, overrun set to 1.
REQ-027 Tick and write in the same cycle: the old pair is written, the new pair is latched, the FSM stays PENDING, overrun is not set.
REQ-028 Latency: write_audio_out no earlier than 1 cycle after a tick.
REQ-029 Outputs hold their last value while write_audio_out=0.

Reset
REQ-030 reset_n=0 at a clock edge: all voices IDLE, amp=0, tick counter=0, output FSM=WAIT_TICK.
REQ-031 Reset values: write_audio_out=0, busy=0, overrun=0, both channel outputs=0.
REQ-032 Reset mid-play or mid-PENDING discards all state; no write is issued after reset deasserts until a new tick.

Configuration
REQ-033 Macro DRUM_STEREO_PAN_EN defined: left = voices 0,2 at full weight plus voices 1,3 arithmetically shifted right by 1; right = the mirror; each channel saturated separately.
REQ-034 Macro DRUM_STEREO_PAN_EN undefined: both channels carry the identical REQ-022 mix; no pan logic is synthesised.

Verification
REQ-035 Reset, allowed=1, no trig -> one write per 1042 clocks, both outputs 0, busy=0.
REQ-036 trig=0001, pitch_sel=0 -> busy[0]=1; square toggles every 3000 clocks; first written sample = +10000000 - 9765 = +9990235; busy falls when amp reaches 0.
REQ-037 All 4 voices triggered in the same cycle, square=1 -> first written sample = 4*9990235 = 39960940 (non-pan); with AMP_INIT=2^30 the sum saturates to 2^31-1.
REQ-038 allowed=0 for 3000 clocks -> overrun=1, and one write of the latest pair once allowed=1.
REQ-039 Retrigger voice 1 mid-decay -> amp restarts at AMP_INIT on the next tick computation, and busy[1] stays high.
REQ-040 reset_n=0 for 1 cycle while PENDING and voices busy -> all outputs 0 next cycle; the first write occurs 1042 clocks after release.
